// File: rtl/fpalu_sequencer.sv
// Multicycle issue controller between FP decode and the FPALU: latches one op, waits its latency, captures results.
// Optional sticky exception-flag CSR is enabled with `define FPSEQ_STICKY_FLAGS_EN.
module fpalu_sequencer #(
  parameter int LAT_ADDSUB = 7,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 6,
  parameter int LAT_SQRT   = 16,
  parameter int LAT_CMP    = 1,
  parameter int LAT_CVT    = 6,
  parameter int LAT_MISC   = 1
) (
  input  logic        iclock,
  input  logic        ireset,
  input  logic        istart,
  input  logic [4:0]  icontrol,
  input  logic [31:0] idataa,
  input  logic [31:0] idatab,
  output logic        ordy,
  output logic [4:0]  ofpcontrol,
  output logic [31:0] ofpa,
  output logic [31:0] ofpb,
  input  logic [31:0] ifpresult,
  input  logic        ifpnan,
  input  logic        ifpzero,
  input  logic        ifpoverflow,
  input  logic        ifpunderflow,
  input  logic        ifpcomp,
  output logic        odone,
  input  logic        iack,
  output logic [31:0] oresult,
  output logic [3:0]  oflags,
  output logic        ocomp,
`ifdef FPSEQ_STICKY_FLAGS_EN
  input  logic        iclrflags,
  output logic [3:0]  ofcsr,
`endif
  output logic        oillegal
);

  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPCEQ    = 5'd5;
  localparam logic [4:0] FOPCLT    = 5'd6;
  localparam logic [4:0] FOPCLE    = 5'd7;
  localparam logic [4:0] FOPCVTSW  = 5'd8;
  localparam logic [4:0] FOPCVTWS  = 5'd9;
  localparam logic [4:0] FOPABS    = 5'd10;
  localparam logic [4:0] FOPNEG    = 5'd11;
  localparam logic [4:0] FOPSIGNJ  = 5'd12;
  localparam logic [4:0] FOPSIGNJN = 5'd13;
  localparam logic [4:0] FOPSIGNJX = 5'd14;

  // A configured latency of 0 still needs one capture cycle.
  localparam logic [7:0] L_ADDSUB = (LAT_ADDSUB < 1) ? 8'd1 : 8'(LAT_ADDSUB);
  localparam logic [7:0] L_MUL    = (LAT_MUL    < 1) ? 8'd1 : 8'(LAT_MUL);
  localparam logic [7:0] L_DIV    = (LAT_DIV    < 1) ? 8'd1 : 8'(LAT_DIV);
  localparam logic [7:0] L_SQRT   = (LAT_SQRT   < 1) ? 8'd1 : 8'(LAT_SQRT);
  localparam logic [7:0] L_CMP    = (LAT_CMP    < 1) ? 8'd1 : 8'(LAT_CMP);
  localparam logic [7:0] L_CVT    = (LAT_CVT    < 1) ? 8'd1 : 8'(LAT_CVT);
  localparam logic [7:0] L_MISC   = (LAT_MISC   < 1) ? 8'd1 : 8'(LAT_MISC);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        illegal_pend_reg;
  logic [7:0]  lat_sel;
  logic        op_legal;
  logic        capture;
  logic [3:0]  cap_flags;

  always_comb begin
    lat_sel  = 8'd1;
    op_legal = 1'b1;
    case (icontrol)
      FOPADD, FOPSUB:                   lat_sel = L_ADDSUB;
      FOPMUL:                           lat_sel = L_MUL;
      FOPDIV:                           lat_sel = L_DIV;
      FOPSQRT:                          lat_sel = L_SQRT;
      FOPCEQ, FOPCLT, FOPCLE:           lat_sel = L_CMP;
      FOPCVTSW, FOPCVTWS:               lat_sel = L_CVT;
      FOPABS, FOPNEG, FOPSIGNJ,
      FOPSIGNJN, FOPSIGNJX:             lat_sel = L_MISC;
      default:                          op_legal = 1'b0;
    endcase
  end

  assign capture   = (state_reg == BUSY) && (cnt_reg == 8'd1);
  assign cap_flags = illegal_pend_reg ? 4'b0000
                                      : {ifpnan, ifpzero, ifpoverflow, ifpunderflow};

  always_ff @(posedge iclock) begin
    if (ireset) begin
      state_reg        <= IDLE;
      cnt_reg          <= 8'd0;
      illegal_pend_reg <= 1'b0;
      ordy             <= 1'b1;
      odone            <= 1'b0;
      ofpcontrol       <= 5'd0;
      ofpa             <= 32'd0;
      ofpb             <= 32'd0;
      oresult          <= 32'd0;
      oflags           <= 4'd0;
      ocomp            <= 1'b0;
      oillegal         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (istart) begin
            ofpcontrol       <= icontrol;
            ofpa             <= idataa;
            ofpb             <= idatab;
            cnt_reg          <= lat_sel;
            illegal_pend_reg <= ~op_legal;
            ordy             <= 1'b0;
            state_reg        <= BUSY;
          end
        end
        BUSY: begin
          if (capture) begin
            oresult   <= illegal_pend_reg ? 32'd0 : ifpresult;
            oflags    <= cap_flags;
            ocomp     <= illegal_pend_reg ? 1'b0 : ifpcomp;
            oillegal  <= illegal_pend_reg;
            odone     <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        DONE: begin
          if (iack) begin
            odone     <= 1'b0;
            ordy      <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          ordy      <= 1'b1;
          odone     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPSEQ_STICKY_FLAGS_EN
  // Clear wins over accumulation when both land on the same edge.
  always_ff @(posedge iclock) begin
    if (ireset || iclrflags) begin
      ofcsr <= 4'd0;
    end else if (capture) begin
      ofcsr <= ofcsr | cap_flags;
    end
  end
`endif

endmodule
